// File: rtl/debug_lcd_fmt.sv
// -----------------------------------------------------------------------------
// debug_lcd_fmt
//
// Formats a snapshot of debug probe channels into a 32-character, two-line
// ASCII frame for a character LCD driver.
//
//   Line 1 (chars 0-15):  <step_cnt:2 hex>'P'<page:1 hex>"    "<live:8 hex>
//   Line 2 (chars 16-31): FPP fields of (DIGITS+1) chars. Each field is a
//                         channel tag digit followed by DIGITS hex digits of
//                         that channel. Unused fields and trailing chars are
//                         spaces.
//
// A refresh starts in IDLE on a trigger and snapshots probe/live/page/step_cnt.
// CONV then produces one character per cycle into a shadow shift register.
// FLUSH copies the frame to str and pulses cls. cls therefore pulses, and str
// changes, 33 cycles after the trigger edge. Steps that arrive while busy are
// all counted, but they collapse into a single pending refresh.
//
// Optional feature (macro DBG_FMT_LIVE_EN):
//   When defined, a change of live relative to its last snapshot while IDLE
//   also triggers a refresh. That refresh does not count as a step.
//   When undefined, live is only sampled on step-triggered refreshes, and no
//   compare logic exists.
//
// Parameters
//   NCH    : number of 32-bit probe channels (1..16)
//   DIGITS : hex digits shown per channel (1..8)
//
// Ports
//   CCLK     in   clock, all state on rising edge
//   RSTN     in   asynchronous active-low reset
//   step     in   single-cycle debounced step pulse
//   clr      in   single-cycle pulse, clears step_cnt (wins over step)
//   probe    in   NCH*32 flat probe bus, channel k = [32k+31:32k]
//   page     in   requested display page
//   live     in   live 32-bit value shown on line 1
//   str      out  32 ASCII chars, char 0 in [255:248]
//   cls      out  one-cycle "string updated" pulse
//   busy     out  high while a refresh is in progress
//   step_cnt out  8-bit wrapping step counter
// -----------------------------------------------------------------------------
module debug_lcd_fmt #(
    parameter  int NCH    = 8,
    parameter  int DIGITS = 3,
    localparam int PW     = 4
) (
    input  logic              CCLK,
    input  logic              RSTN,
    input  logic              step,
    input  logic              clr,
    input  logic [NCH*32-1:0] probe,
    input  logic [PW-1:0]     page,
    input  logic [31:0]       live,
    output logic [255:0]      str,
    output logic              cls,
    output logic              busy,
    output logic [7:0]        step_cnt
);

    localparam int FPP     = 16 / (DIGITS + 1);
    localparam int NPG_RAW = (NCH + FPP - 1) / FPP;
    localparam int NPAGE   = (NPG_RAW < 1) ? 1 : NPG_RAW;

    localparam logic [PW-1:0] PG_MAX = PW'(NPAGE - 1);
    localparam logic [7:0]    SP     = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FLUSH
    } state_t;

    state_t              state;
    logic [4:0]          idx;
    logic                pending;
    logic                trig;
    logic [7:0]          cnt_nxt;

    logic [NCH*32-1:0]   probe_p0;
    logic [31:0]         live_p0;
    logic [PW-1:0]       pg_p0;
    logic [7:0]          cnt_p0;

    logic [255:0]        shadow_p1;
    logic [7:0]          char_nxt;

    int                  pos;
    int                  fld;
    int                  off;
    int                  chn;
    logic [31:0]         ch_word;

    // Uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Pages past the last populated one show the last page.
    function automatic logic [PW-1:0] clamp_page(input logic [PW-1:0] p);
        return (p > PG_MAX) ? PG_MAX : p;
    endfunction

    // clr wins over a coincident step; the counter runs in every state.
    always_comb begin
        if (clr) begin
            cnt_nxt = 8'd0;
        end else if (step) begin
            cnt_nxt = step_cnt + 8'd1;
        end else begin
            cnt_nxt = step_cnt;
        end
    end

`ifdef DBG_FMT_LIVE_EN
    logic live_chg;

    assign live_chg = (live != live_p0);
    assign trig     = step | pending | live_chg;
`else
    assign trig     = step | pending;
`endif

    // ---- stage p0: snapshot taken on the edge that starts a refresh ----
    always_ff @(posedge CCLK) begin
        if (state == S_IDLE && trig) begin
            probe_p0 <= probe;
            pg_p0    <= clamp_page(page);
            cnt_p0   <= cnt_nxt;
        end
    end

    // The live snapshot is reset because it is also the reference for the
    // optional change detector.
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            live_p0 <= '0;
        end else if (state == S_IDLE && trig) begin
            live_p0 <= live;
        end
    end

    // Character generator for position idx from the p0 snapshot.
    always_comb begin
        char_nxt = SP;
        ch_word  = '0;
        pos      = 0;
        fld      = 0;
        off      = 0;
        chn      = 0;
        if (idx == 5'd0) begin
            char_nxt = hex_char(cnt_p0[7:4]);
        end else if (idx == 5'd1) begin
            char_nxt = hex_char(cnt_p0[3:0]);
        end else if (idx == 5'd2) begin
            char_nxt = 8'h50;
        end else if (idx == 5'd3) begin
            char_nxt = hex_char(pg_p0);
        end else if (idx < 5'd8) begin
            char_nxt = SP;
        end else if (idx < 5'd16) begin
            // chars 8..15 walk live from the most significant nibble down
            char_nxt = hex_char(4'(live_p0 >> (4 * (15 - int'(idx)))));
        end else begin
            pos     = int'(idx) - 16;
            fld     = pos / (DIGITS + 1);
            off     = pos % (DIGITS + 1);
            chn     = int'(pg_p0) * FPP + fld;
            ch_word = 32'(probe_p0 >> (32 * chn));
            // fld >= FPP covers trailing chars when 16 is not a multiple
            // of DIGITS+1; chn >= NCH covers empty fields on the last page.
            if (fld < FPP && chn < NCH) begin
                if (off == 0) begin
                    char_nxt = hex_char(4'(chn));
                end else begin
                    char_nxt = hex_char(4'(ch_word >> (4 * (DIGITS - off))));
                end
            end
        end
    end

    // ---- stage p1: shadow frame, filled char 0 first by shifting left ----
    always_ff @(posedge CCLK) begin
        if (state == S_CONV) begin
            shadow_p1 <= {shadow_p1[247:0], char_nxt};
        end
    end

    // ---- stage p2: control FSM and registered outputs ----
    always_ff @(posedge CCLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            idx      <= '0;
            pending  <= 1'b0;
            step_cnt <= '0;
            cls      <= 1'b0;
            busy     <= 1'b0;
            str      <= {32{SP}};
        end else begin
            step_cnt <= cnt_nxt;
            cls      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig) begin
                        state   <= S_CONV;
                        idx     <= '0;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_CONV: begin
                    if (step) begin
                        pending <= 1'b1;
                    end
                    // idx wraps back to 0 after the last character
                    idx <= idx + 5'd1;
                    if (idx == 5'd31) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (step) begin
                        pending <= 1'b1;
                    end
                    str   <= shadow_p1;
                    cls   <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
